mac_quad_to_ps2: RTL and testbench

- Decodes Mac-style mouse quadrature lines (X1/X2, Y1/Y2, active-low button) back into the 25-bit packed PS/2 mouse word used by the mouse path.
- Sits at the input side of the mouse path and serves three purposes:
  - loopback verification of the PS/2-to-quadrature encoder;
  - bridging native quadrature mice into logic that consumes PS/2 packets;
  - host-side emulation.
- Per-axis signed saturating accumulators are drained into one packet per report period.

---
 rtl/mouse_pkg.sv | 44 ++++
 rtl/quad_axis_decoder.sv | 79 +++++++
 rtl/mac_quad_to_ps2.sv | 98 +++++++++
 tb/tb_mac_quad_to_ps2.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse path: PS/2 packet layout, byte0 bit map
// and the movement accumulator range.
package mouse_pkg;

   localparam int PKT_W      = 25;
   localparam int PKT_STROBE = 24;
   localparam int PKT_Y_LSB  = 16;
   localparam int PKT_X_LSB  = 8;
   localparam int PKT_B0_LSB = 0;

   localparam int B0_LBUT    = 0;
   localparam int B0_RBUT    = 1;
   localparam int B0_MBUT    = 2;
   localparam int B0_ALWAYS1 = 3;
   localparam int B0_XSGN    = 4;
   localparam int B0_YSGN    = 5;
   localparam int B0_XOVR    = 6;
   localparam int B0_YOVR    = 7;

   localparam int ACC_W   = 9;
   localparam int ACC_MAX = 255;
   localparam int ACC_MIN = -256;

   localparam logic [PKT_W-1:0] PKT_RESET = 25'h0000008;

   typedef logic signed [ACC_W-1:0] acc_t;

   function automatic logic [7:0] pack_byte0(input logic yovr, input logic xovr,
                                             input logic ysgn, input logic xsgn,
                                             input logic lbut);
      logic [7:0] b;
      b             = '0;
      b[B0_YOVR]    = yovr;
      b[B0_XOVR]    = xovr;
      b[B0_YSGN]    = ysgn;
      b[B0_XSGN]    = xsgn;
      b[B0_ALWAYS1] = 1'b1;
      b[B0_MBUT]    = 1'b0;
      b[B0_RBUT]    = 1'b0;
      b[B0_LBUT]    = lbut;
      return b;
   endfunction

endpackage

// File: rtl/quad_axis_decoder.sv
// One quadrature axis: synchronizes both phases, decodes a step on each
// phase-A edge and keeps a signed saturating movement count.
module quad_axis_decoder
   import mouse_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_a,
   input  logic i_b,
   input  logic i_clr,
   output acc_t o_acc,
   output logic o_ovr
);

   localparam acc_t LIM_HI = acc_t'(ACC_MAX);
   localparam acc_t LIM_LO = acc_t'(ACC_MIN);

   logic [SYNC_STAGES-1:0] r_sync_a;
   logic [SYNC_STAGES-1:0] r_sync_b;
   logic                   r_prev_a;
   acc_t                   r_acc;
   logic                   r_ovr;

   logic w_a;
   logic w_b;
   logic w_edge;
   logic w_up;

   assign w_a    = r_sync_a[SYNC_STAGES-1];
   assign w_b    = r_sync_b[SYNC_STAGES-1];
   assign w_edge = (w_a != r_prev_a);
   assign w_up   = (w_a != w_b);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync_a <= '0;
         r_sync_b <= '0;
         r_prev_a <= 1'b0;
      end else begin
         r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], i_a};
         r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], i_b};
         r_prev_a <= w_a;
      end
   end

   // A clear drains the old count; a step arriving in the same cycle starts the new one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_ovr <= 1'b0;
      end else if (i_clr) begin
         r_ovr <= 1'b0;
         if (!w_edge)
            r_acc <= '0;
         else if (w_up)
            r_acc <= acc_t'(1);
         else
            r_acc <= acc_t'(-1);
      end else if (w_edge) begin
         if (w_up) begin
            if (r_acc == LIM_HI)
               r_ovr <= 1'b1;
            else
               r_acc <= r_acc + acc_t'(1);
         end else begin
            if (r_acc == LIM_LO)
               r_ovr <= 1'b1;
            else
               r_acc <= r_acc - acc_t'(1);
         end
      end
   end

   assign o_acc = r_acc;
   assign o_ovr = r_ovr;

endmodule

// File: rtl/mac_quad_to_ps2.sv
// Mac quadrature mouse lines to packed PS/2 mouse word: two axis decoders,
// button sync, report timer and the packet register.
module mac_quad_to_ps2
   import mouse_pkg::*;
#(
   parameter int REPORT_DIV  = 4096,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             x1,
   input  logic             x2,
   input  logic             y1,
   input  logic             y2,
   input  logic             button,
   output logic [PKT_W-1:0] ps2_mouse
);

   localparam int              CNT_W    = $clog2(REPORT_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPORT_DIV - 1);

   logic [SYNC_STAGES-1:0] r_btn_sync;
   logic                   r_btn_last;
   logic [CNT_W-1:0]       r_cnt;
   logic [PKT_W-1:0]       r_pkt;

   logic             w_btn;
   logic             w_tick;
   logic             w_emit;
   acc_t             w_acc_x;
   acc_t             w_acc_y;
   logic             w_ovr_x;
   logic             w_ovr_y;
   logic [PKT_W-1:0] w_pkt;

   quad_axis_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_x (
      .clk   (clk),
      .reset (reset),
      .i_a   (x1),
      .i_b   (x2),
      .i_clr (w_emit),
      .o_acc (w_acc_x),
      .o_ovr (w_ovr_x)
   );

   quad_axis_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_y (
      .clk   (clk),
      .reset (reset),
      .i_a   (y1),
      .i_b   (y2),
      .i_clr (w_emit),
      .o_acc (w_acc_y),
      .o_ovr (w_ovr_y)
   );

   assign w_btn  = r_btn_sync[SYNC_STAGES-1];
   assign w_tick = ce && (r_cnt == CNT_LAST);
   assign w_emit = w_tick && ((w_acc_x != '0) || (w_acc_y != '0) ||
                              (w_btn != r_btn_last) || w_ovr_x || w_ovr_y);

   // Button is active-low on the pin, so the idle synchronizer state is 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_btn_sync <= '1;
      else
         r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], button};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (ce)
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
   end

   always_comb begin
      w_pkt                    = '0;
      w_pkt[PKT_STROBE]        = ~r_pkt[PKT_STROBE];
      w_pkt[PKT_Y_LSB +: 8]    = w_acc_y[7:0];
      w_pkt[PKT_X_LSB +: 8]    = w_acc_x[7:0];
      w_pkt[PKT_B0_LSB +: 8]   = pack_byte0(w_ovr_y, w_ovr_x, w_acc_y[ACC_W-1],
                                            w_acc_x[ACC_W-1], ~w_btn);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pkt      <= PKT_RESET;
         r_btn_last <= 1'b1;
      end else if (w_emit) begin
         r_pkt      <= w_pkt;
         r_btn_last <= w_btn;
      end
   end

   assign ps2_mouse = r_pkt;

endmodule

// File: tb/tb_mac_quad_to_ps2.sv
// Bench for mac_quad_to_ps2: a cycle-level behavioural model compared every
// cycle, plus literal packet checks for each directed scenario.
module tb_mac_quad_to_ps2;

   localparam int N = 16;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        x1 = 1'b0, x2 = 1'b0, y1 = 1'b0, y2 = 1'b0;
   logic        button = 1'b1;
   logic [24:0] ps2_mouse;

   int n_vec  = 0;
   int n_fail = 0;
   bit run    = 1'b0;

   mac_quad_to_ps2 #(.REPORT_DIV(N), .SYNC_STAGES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .x1        (x1),
      .x2        (x2),
      .y1        (y1),
      .y2        (y2),
      .button    (button),
      .ps2_mouse (ps2_mouse)
   );

   always #5 clk = ~clk;

   // Model: each pin is seen S samples late; a step happens when the delayed
   // phase A differs from the sample before it.
   logic        hx1 [0:S];
   logic        hx2 [0:S];
   logic        hy1 [0:S];
   logic        hy2 [0:S];
   logic        hb  [0:S];
   int          m_cnt, ax, ay, sx, sy;
   bit          ox, oy, tick;
   logic        m_last, bs;
   logic [8:0]  x9, y9;
   logic [24:0] m_exp;

   task automatic model_reset();
      for (int i = 0; i <= S; i++) begin
         hx1[i] = 1'b0; hx2[i] = 1'b0; hy1[i] = 1'b0; hy2[i] = 1'b0; hb[i] = 1'b1;
      end
      m_cnt = 0; ax = 0; ay = 0; ox = 1'b0; oy = 1'b0;
      m_last = 1'b1;
      m_exp = 25'h0000008;
   endtask

   function automatic int step_of(input logic n, input logic p, input logic b);
      if (n == p) return 0;
      return (n != b) ? 1 : -1;
   endfunction

   always @(posedge reset) model_reset();

   always @(posedge clk) begin
      if (reset) begin
         model_reset();
      end else begin
         sx = step_of(hx1[S-1], hx1[S], hx2[S-1]);
         sy = step_of(hy1[S-1], hy1[S], hy2[S-1]);
         bs = hb[S-1];
         tick = 1'b0;
         if (ce) begin
            m_cnt++;
            if (m_cnt == N) begin
               m_cnt = 0;
               tick = 1'b1;
            end
         end
         if (tick && (ax != 0 || ay != 0 || bs != m_last || ox || oy)) begin
            x9 = ax[8:0];
            y9 = ay[8:0];
            m_exp = {~m_exp[24], y9[7:0], x9[7:0], oy, ox, y9[8], x9[8],
                     1'b1, 1'b0, 1'b0, ~bs};
            ax = sx; ay = sy; ox = 1'b0; oy = 1'b0;
            m_last = bs;
         end else begin
            if (ax + sx > 255 || ax + sx < -256) ox = 1'b1; else ax = ax + sx;
            if (ay + sy > 255 || ay + sy < -256) oy = 1'b1; else ay = ay + sy;
         end
         for (int i = S; i > 0; i--) begin
            hx1[i] = hx1[i-1]; hx2[i] = hx2[i-1];
            hy1[i] = hy1[i-1]; hy2[i] = hy2[i-1];
            hb[i]  = hb[i-1];
         end
         hx1[0] = x1; hx2[0] = x2; hy1[0] = y1; hy2[0] = y2; hb[0] = button;
      end
   end

   always @(negedge clk) begin
      if (run && !reset) begin
         n_vec++;
         if (ps2_mouse !== m_exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got %h want %h", $time, ps2_mouse, m_exp);
         end
      end
   end

   task automatic check24(input string nm, input logic [23:0] want);
      n_vec++;
      if (ps2_mouse[23:0] !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", nm, ps2_mouse[23:0], want);
      end
   endtask

   task automatic check_full(input string nm, input logic [24:0] want);
      n_vec++;
      if (ps2_mouse !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", nm, ps2_mouse, want);
      end
   endtask

   task automatic wait_toggle(input string nm, input int budget);
      logic old;
      bit   got;
      old = ps2_mouse[24];
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (ps2_mouse[24] !== old) got = 1'b1;
      end
      n_vec++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s no strobe toggle within %0d cycles, strobe %b", nm, budget, ps2_mouse[24]);
      end
   endtask

   task automatic no_toggle(input string nm, input int cycles);
      logic old;
      old = ps2_mouse[24];
      repeat (cycles) @(negedge clk);
      n_vec++;
      if (ps2_mouse[24] !== old) begin
         n_fail++;
         $display("FAIL %s strobe got %b want %b", nm, ps2_mouse[24], old);
      end
   endtask

   task automatic step_x_plus(input int hold);
      if (x1) begin x1 = 1'b0; x2 = 1'b1; end
      else    begin x1 = 1'b1; x2 = 1'b0; end
      repeat (hold) @(negedge clk);
   endtask

   logic old_strobe;

   initial begin
      repeat (3) @(negedge clk);
      check_full("reset_value", 25'h0000008);
      reset = 1'b0;
      run   = 1'b1;

      // three +X steps while the timer is held, then one report
      step_x_plus(4); step_x_plus(4); step_x_plus(4);
      repeat (4) @(negedge clk);
      ce = 1'b1;
      wait_toggle("plus_x_strobe", 40);
      check24("plus_x_pkt", 24'h000308);
      no_toggle("plus_x_single", 40);

      // two -Y steps
      ce = 1'b0;
      y1 = 1'b1; y2 = 1'b1; repeat (4) @(negedge clk);
      y1 = 1'b0; y2 = 1'b0; repeat (4) @(negedge clk);
      repeat (4) @(negedge clk);
      ce = 1'b1;
      wait_toggle("minus_y_strobe", 40);
      check24("minus_y_pkt", 24'hFE0028);

      // 300 +X steps in one window saturate at +255
      ce = 1'b0;
      for (int i = 0; i < 300; i++) step_x_plus(2);
      repeat (4) @(negedge clk);
      ce = 1'b1;
      wait_toggle("sat_strobe", 40);
      check24("sat_pkt", 24'h00FF48);
      no_toggle("sat_quiet", 40);

      // button press and release
      button = 1'b0;
      wait_toggle("press_strobe", 40);
      check24("press_pkt", 24'h000009);
      no_toggle("press_quiet", 40);
      button = 1'b1;
      wait_toggle("release_strobe", 40);
      check24("release_pkt", 24'h000008);

      // X edge reaches the decoder on the same edge as an emitting tick
      ce = 1'b0;
      y1 = 1'b1; y2 = 1'b0;
      repeat (5) @(negedge clk);
      old_strobe = ps2_mouse[24];
      for (int i = 0; i < 16; i++) begin
         if (i == 0) ce = 1'b1;
         if (i == 13) begin x1 = 1'b0; x2 = 1'b1; end
         @(negedge clk);
      end
      n_vec++;
      if (ps2_mouse[24] === old_strobe) begin
         n_fail++;
         $display("FAIL tick_strobe got %b want %b", ps2_mouse[24], ~old_strobe);
      end
      check24("tick_pkt", 24'h010008);
      wait_toggle("after_tick_strobe", 40);
      check24("after_tick_pkt", 24'h000108);

      // reset in mid-window discards the partial count and restarts the timer
      for (int i = 0; i < 5; i++) step_x_plus(2);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_full("reset_mid", 25'h0000008);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      no_toggle("reset_no_old_tick", 15);
      check_full("reset_hold", 25'h0000008);
      wait_toggle("post_reset_strobe", 3);
      check24("post_reset_pkt", 24'h010108);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
